// File: rtl/hangman_round_ctrl.sv
// hangman_round_ctrl: single-round hangman controller tracking revealed slots,
// guessed letters and misses, declaring win or loss.
module hangman_round_ctrl #(
    parameter  int WORD_LEN  = 6,
    parameter  int MAX_WRONG = 4,
    localparam int WW        = $clog2(MAX_WRONG + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [5*WORD_LEN-1:0] word_in,
    input  logic                  guess_valid,
    input  logic [4:0]            guess_letter,
    output logic                  guess_ready,
    output logic [1:0]            state,
    output logic [WORD_LEN-1:0]   revealed,
    output logic [25:0]           guessed,
    output logic [WW-1:0]         wrong_count,
    output logic [WW-1:0]         lives_left,
    output logic                  hit,
    output logic                  miss,
    output logic                  dup
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_WIN  = 2'd2;
    localparam logic [1:0] S_LOSE = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [5*WORD_LEN-1:0] r_word;
    logic [WORD_LEN-1:0]   r_revealed;
    logic [25:0]           r_guessed;
    logic [WW-1:0]         r_wrong;
    logic                  r_hit;
    logic                  r_miss;
    logic                  r_dup;
    logic [WORD_LEN-1:0]   w_unused;
    logic [WORD_LEN-1:0]   w_match;
    logic [25:0]           w_letter_bit;
    logic                  w_accept;
    logic                  w_dup;
    logic                  w_any;
    logic                  w_new;
    logic [WORD_LEN-1:0]   w_rev_next;
    logic [WW-1:0]         w_wrong_next;

    // Unused slots carry codes >= 26, so they can never match an accepted guess.
    for (genvar i = 0; i < WORD_LEN; i++) begin : g_slot
        assign w_unused[i] = word_in[5*i +: 5] >= 5'd26;
        assign w_match[i]  = r_word[5*i +: 5] == guess_letter;
    end

    assign w_letter_bit = 26'(1) << guess_letter;
    assign w_accept     = guess_valid && r_state == S_PLAY && guess_letter < 5'd26;
    assign w_dup        = |(r_guessed & w_letter_bit);
    assign w_any        = |w_match;
    assign w_new        = w_accept && !w_dup;
    assign w_rev_next   = r_revealed | w_match;
    assign w_wrong_next = (r_wrong == WW'(MAX_WRONG)) ? r_wrong : r_wrong + WW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (start)
            w_state_next = &w_unused ? S_WIN : S_PLAY;
        else if (w_new && w_any && &w_rev_next)
            w_state_next = S_WIN;
        else if (w_new && !w_any && w_wrong_next == WW'(MAX_WRONG))
            w_state_next = S_LOSE;
    end

    always_comb begin
        guess_ready = r_state == S_PLAY;
        state       = r_state;
        revealed    = r_revealed;
        guessed     = r_guessed;
        wrong_count = r_wrong;
        lives_left  = WW'(MAX_WRONG) - r_wrong;
        hit         = r_hit;
        miss        = r_miss;
        dup         = r_dup;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word     <= '0;
            r_revealed <= '0;
            r_guessed  <= '0;
            r_wrong    <= '0;
            r_hit      <= 1'b0;
            r_miss     <= 1'b0;
            r_dup      <= 1'b0;
        end else if (start) begin
            r_word     <= word_in;
            r_revealed <= w_unused;
            r_guessed  <= '0;
            r_wrong    <= '0;
            r_hit      <= 1'b0;
            r_miss     <= 1'b0;
            r_dup      <= 1'b0;
        end else begin
            r_hit  <= w_new && w_any;
            r_miss <= w_new && !w_any;
            r_dup  <= w_accept && w_dup;
            if (w_new) begin
                r_guessed  <= r_guessed | w_letter_bit;
                r_revealed <= w_rev_next;
                if (!w_any)
                    r_wrong <= w_wrong_next;
            end
        end
    end
endmodule
